// File: rtl/rfdc_pkg.sv
// Shared types and constants for the RFDC calibration-freeze sequencer.
package rfdc_pkg;

    typedef enum logic [1:0] {
        NEVER = 2'd0,
        FORCE = 2'd1,
        AUTO  = 2'd2,
        RSVD  = 2'd3
    } cal_mode_t;

    typedef enum logic [1:0] {
        THAWED      = 2'd0,
        FREEZE_WAIT = 2'd1,
        FROZEN      = 2'd2,
        THAW_WAIT   = 2'd3
    } cal_state_t;

    localparam int TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/rfdc_cal_freeze_ctrl_if.sv
// RFDC-side handshake lines: signal detect and frozen acknowledge in, freeze request out.
interface rfdc_cal_freeze_ctrl_if #(
    parameter int NCHAN = 8
);
    logic [NCHAN-1:0] adc_sig_detect;
    logic [NCHAN-1:0] adc_cal_frozen;
    logic [NCHAN-1:0] adc_cal_freeze;

    modport master (
        input  adc_sig_detect,
        input  adc_cal_frozen,
        output adc_cal_freeze
    );

    modport slave (
        output adc_sig_detect,
        output adc_cal_frozen,
        input  adc_cal_freeze
    );
endinterface

// File: rtl/rfdc_cal_freeze_chan.sv
// One channel of the calibration-freeze sequencer: FSM, dwell counter, ack wait counter, sticky error.
//
// state       | meaning
// ------------+----------------------------------------------------------
// THAWED      | calibration running, freeze low, watching for signal loss
// FREEZE_WAIT | freeze high, waiting for frozen ack (or timeout)
// FROZEN      | calibration frozen, watching for signal return / mode
// THAW_WAIT   | freeze low, waiting for frozen ack to drop (or timeout)
module rfdc_cal_freeze_chan
    import rfdc_pkg::*;
#(
    parameter int DWELL_BITS = 16,
    parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  cal_mode_t             mode_i,
    input  logic [DWELL_BITS-1:0] freeze_dwell_i,
    input  logic [DWELL_BITS-1:0] thaw_dwell_i,
    input  logic                  err_clr_i,
    input  logic                  sd_i,
    input  logic                  fz_i,
    output logic                  freeze_o,
    output logic                  frozen_o,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int WAIT_BITS = $clog2(TIMEOUT + 1);

    cal_state_t            state_q, state_d;
    logic [DWELL_BITS-1:0] dwell_q, dwell_d;
    logic [WAIT_BITS-1:0]  wait_q, wait_d;
    logic                  err_q, err_d;

    logic [DWELL_BITS-1:0] fdwell_eff, tdwell_eff, dwell_inc;
    logic                  wait_done;

    assign fdwell_eff = (freeze_dwell_i == '0) ? DWELL_BITS'(1) : freeze_dwell_i;
    assign tdwell_eff = (thaw_dwell_i == '0) ? DWELL_BITS'(1) : thaw_dwell_i;
    assign dwell_inc  = (dwell_q == '1) ? dwell_q : dwell_q + DWELL_BITS'(1);
    // Exit lands exactly TIMEOUT cycles after entry, so compare the pre-increment value.
    assign wait_done  = (wait_q == WAIT_BITS'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        wait_d  = wait_q;
        err_d   = err_q & ~err_clr_i;

        unique case (state_q)
            THAWED: begin
                dwell_d = sd_i ? '0 : dwell_inc;
                if (mode_i == FORCE) begin
                    state_d = FREEZE_WAIT;
                end else if (mode_i == AUTO && dwell_q >= fdwell_eff) begin
                    state_d = FREEZE_WAIT;
                end
            end
            FREEZE_WAIT: begin
                wait_d = wait_q + WAIT_BITS'(1);
                if (fz_i) begin
                    state_d = FROZEN;
                end else if (wait_done) begin
                    state_d = FROZEN;
                    err_d   = 1'b1;
                end
            end
            FROZEN: begin
                dwell_d = sd_i ? dwell_inc : '0;
                if (mode_i == NEVER || mode_i == RSVD) begin
                    state_d = THAW_WAIT;
                end else if (mode_i == AUTO && dwell_q >= tdwell_eff) begin
                    state_d = THAW_WAIT;
                end
            end
            THAW_WAIT: begin
                wait_d = wait_q + WAIT_BITS'(1);
                if (!fz_i) begin
                    state_d = THAWED;
                end else if (wait_done) begin
                    state_d = THAWED;
                    err_d   = 1'b1;
                end
            end
        endcase

        if (mode_i != AUTO || state_d != state_q) begin
            dwell_d = '0;
        end
        if (state_d != state_q) begin
            wait_d = '0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= THAWED;
            dwell_q <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    assign freeze_o = (state_q == FREEZE_WAIT) || (state_q == FROZEN);
    assign frozen_o = (state_q == FROZEN);
    assign busy_o   = (state_q == FREEZE_WAIT) || (state_q == THAW_WAIT);
    assign err_o    = err_q;

endmodule

// File: rtl/rfdc_cal_freeze_ctrl.sv
// Per-channel calibration-freeze sequencer for the RFDC ADC tiles: input synchronizers
// plus one freeze FSM per channel.
module rfdc_cal_freeze_ctrl
    import rfdc_pkg::*;
#(
    parameter int NCHAN      = 8,
    parameter int DWELL_BITS = 16,
    parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [2*NCHAN-1:0]      mode_i,
    input  logic [DWELL_BITS-1:0]   freeze_dwell_i,
    input  logic [DWELL_BITS-1:0]   thaw_dwell_i,
    input  logic                    err_clr_i,
    rfdc_cal_freeze_ctrl_if.master  rfdc,
    output logic [NCHAN-1:0]        frozen_o,
    output logic [NCHAN-1:0]        busy_o,
    output logic [NCHAN-1:0]        timeout_err_o
);

    logic [NCHAN-1:0] sd_meta_q, sd_s_q;
    logic [NCHAN-1:0] fz_meta_q, fz_s_q;
    logic [NCHAN-1:0] freeze_w;

    // Both RFDC status lines are asynchronous to aclk.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sd_meta_q <= '0;
            sd_s_q    <= '0;
            fz_meta_q <= '0;
            fz_s_q    <= '0;
        end else begin
            sd_meta_q <= rfdc.adc_sig_detect;
            sd_s_q    <= sd_meta_q;
            fz_meta_q <= rfdc.adc_cal_frozen;
            fz_s_q    <= fz_meta_q;
        end
    end

    for (genvar c = 0; c < NCHAN; c++) begin : g_chan
        rfdc_cal_freeze_chan #(
            .DWELL_BITS (DWELL_BITS),
            .TIMEOUT    (TIMEOUT)
        ) u_chan (
            .aclk           (aclk),
            .aresetn        (aresetn),
            .mode_i         (cal_mode_t'(mode_i[2*c +: 2])),
            .freeze_dwell_i (freeze_dwell_i),
            .thaw_dwell_i   (thaw_dwell_i),
            .err_clr_i      (err_clr_i),
            .sd_i           (sd_s_q[c]),
            .fz_i           (fz_s_q[c]),
            .freeze_o       (freeze_w[c]),
            .frozen_o       (frozen_o[c]),
            .busy_o         (busy_o[c]),
            .err_o          (timeout_err_o[c])
        );
    end

    assign rfdc.adc_cal_freeze = freeze_w;

endmodule

// File: tb/tb_rfdc_cal_freeze_ctrl.sv
// Directed bench for rfdc_cal_freeze_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_rfdc_cal_freeze_ctrl;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [15:0] mode;
    logic [15:0] freeze_dwell;
    logic [15:0] thaw_dwell;
    logic        err_clr;
    logic [7:0]  frozen;
    logic [7:0]  busy;
    logic [7:0]  err;

    int checks = 0;
    int errors = 0;

    rfdc_cal_freeze_ctrl_if #(.NCHAN(8)) rif ();

    rfdc_cal_freeze_ctrl #(
        .NCHAN      (8),
        .DWELL_BITS (16),
        .TIMEOUT    (1024)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .mode_i         (mode),
        .freeze_dwell_i (freeze_dwell),
        .thaw_dwell_i   (thaw_dwell),
        .err_clr_i      (err_clr),
        .rfdc           (rif),
        .frozen_o       (frozen),
        .busy_o         (busy),
        .timeout_err_o  (err)
    );

    always #5 aclk = ~aclk;

    task automatic tick(input int n);
        repeat (n) @(negedge aclk);
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        mode = '1; freeze_dwell = '1; thaw_dwell = '1; err_clr = 1'b1;
        rif.adc_sig_detect = '1; rif.adc_cal_frozen = '1;
        tick(4);
        checks++; if (rif.adc_cal_freeze !== 8'h00) begin errors++; $display("FAIL rst_freeze got %h exp 00", rif.adc_cal_freeze); end
        checks++; if (frozen !== 8'h00) begin errors++; $display("FAIL rst_frozen got %h exp 00", frozen); end
        checks++; if (busy !== 8'h00) begin errors++; $display("FAIL rst_busy got %h exp 00", busy); end
        checks++; if (err !== 8'h00) begin errors++; $display("FAIL rst_err got %h exp 00", err); end
        mode = '0; freeze_dwell = '0; thaw_dwell = '0; err_clr = 1'b0;
        rif.adc_cal_frozen = '0;
        aresetn = 1'b1;
        tick(5);
        checks++; if (rif.adc_cal_freeze !== 8'h00) begin errors++; $display("FAIL post_rst_freeze got %h exp 00", rif.adc_cal_freeze); end
        checks++; if ({frozen, busy, err} !== 24'h0) begin errors++; $display("FAIL post_rst_status got %h exp 000000", {frozen, busy, err}); end
    endtask

    task automatic test_auto_freeze();
        freeze_dwell = 16'd10; thaw_dwell = 16'd4;
        mode = 16'h0080;
        tick(3);
        rif.adc_sig_detect[3] = 1'b0;
        tick(12);
        checks++; if (rif.adc_cal_freeze !== 8'h00) begin errors++; $display("FAIL auto_c12 got %h exp 00", rif.adc_cal_freeze); end
        tick(1);
        checks++; if (rif.adc_cal_freeze !== 8'h08) begin errors++; $display("FAIL auto_c13 got %h exp 08", rif.adc_cal_freeze); end
        checks++; if (busy !== 8'h08) begin errors++; $display("FAIL auto_busy got %h exp 08", busy); end
        tick(7);
        rif.adc_cal_frozen[3] = 1'b1;
        tick(2);
        checks++; if (frozen !== 8'h00) begin errors++; $display("FAIL ack_c22 got %h exp 00", frozen); end
        tick(1);
        checks++; if (frozen !== 8'h08) begin errors++; $display("FAIL ack_c23 got %h exp 08", frozen); end
        checks++; if (busy !== 8'h00 || rif.adc_cal_freeze !== 8'h08) begin errors++; $display("FAIL ack_other got busy %h freeze %h exp 00 08", busy, rif.adc_cal_freeze); end
        rif.adc_sig_detect[3] = 1'b1;
        tick(6);
        checks++; if (rif.adc_cal_freeze !== 8'h08) begin errors++; $display("FAIL thaw_c6 got %h exp 08", rif.adc_cal_freeze); end
        tick(1);
        checks++; if (rif.adc_cal_freeze !== 8'h00 || busy !== 8'h08) begin errors++; $display("FAIL thaw_c7 got freeze %h busy %h exp 00 08", rif.adc_cal_freeze, busy); end
        rif.adc_cal_frozen[3] = 1'b0;
        tick(3);
        checks++; if (busy !== 8'h00 || frozen !== 8'h00) begin errors++; $display("FAIL thaw_done got busy %h frozen %h exp 00 00", busy, frozen); end
        mode = '0;
        tick(2);
    endtask

    task automatic test_glitch_and_zero_dwell();
        freeze_dwell = 16'd10;
        mode = 16'h0800;
        tick(3);
        rif.adc_sig_detect[5] = 1'b0;
        tick(9);
        rif.adc_sig_detect[5] = 1'b1;
        tick(15);
        checks++; if (rif.adc_cal_freeze !== 8'h00 || busy !== 8'h00) begin errors++; $display("FAIL glitch got freeze %h busy %h exp 00 00", rif.adc_cal_freeze, busy); end
        freeze_dwell = 16'd0; thaw_dwell = 16'd0;
        tick(1);
        rif.adc_sig_detect[5] = 1'b0;
        tick(3);
        checks++; if (rif.adc_cal_freeze !== 8'h00) begin errors++; $display("FAIL dwell0_c3 got %h exp 00", rif.adc_cal_freeze); end
        tick(1);
        checks++; if (rif.adc_cal_freeze !== 8'h20) begin errors++; $display("FAIL dwell0_c4 got %h exp 20", rif.adc_cal_freeze); end
        rif.adc_cal_frozen[5] = 1'b1;
        tick(3);
        checks++; if (frozen !== 8'h20) begin errors++; $display("FAIL dwell0_frozen got %h exp 20", frozen); end
        rif.adc_sig_detect[5] = 1'b1;
        tick(3);
        checks++; if (rif.adc_cal_freeze !== 8'h20) begin errors++; $display("FAIL tdwell0_c3 got %h exp 20", rif.adc_cal_freeze); end
        tick(1);
        checks++; if (rif.adc_cal_freeze !== 8'h00 || busy !== 8'h20) begin errors++; $display("FAIL tdwell0_c4 got freeze %h busy %h exp 00 20", rif.adc_cal_freeze, busy); end
        rif.adc_cal_frozen[5] = 1'b0;
        tick(3);
        checks++; if (busy !== 8'h00) begin errors++; $display("FAIL tdwell0_done got %h exp 00", busy); end
        mode = '0;
        tick(2);
    endtask

    task automatic test_force_never();
        mode = 16'h0001;
        tick(1);
        checks++; if (rif.adc_cal_freeze !== 8'h01 || busy !== 8'h01) begin errors++; $display("FAIL force_c1 got freeze %h busy %h exp 01 01", rif.adc_cal_freeze, busy); end
        mode = 16'h0000;
        tick(5);
        checks++; if (rif.adc_cal_freeze !== 8'h01 || busy !== 8'h01) begin errors++; $display("FAIL never_in_wait got freeze %h busy %h exp 01 01", rif.adc_cal_freeze, busy); end
        rif.adc_cal_frozen[0] = 1'b1;
        tick(2);
        checks++; if (busy !== 8'h01) begin errors++; $display("FAIL force_ack_c2 got %h exp 01", busy); end
        tick(1);
        checks++; if (frozen !== 8'h01 || busy !== 8'h00) begin errors++; $display("FAIL force_ack_c3 got frozen %h busy %h exp 01 00", frozen, busy); end
        tick(1);
        checks++; if (frozen !== 8'h00 || busy !== 8'h01 || rif.adc_cal_freeze !== 8'h00) begin errors++; $display("FAIL never_thaw got frozen %h busy %h freeze %h exp 00 01 00", frozen, busy, rif.adc_cal_freeze); end
        rif.adc_cal_frozen[0] = 1'b0;
        tick(3);
        checks++; if (busy !== 8'h00) begin errors++; $display("FAIL never_done got %h exp 00", busy); end
    endtask

    task automatic test_timeout();
        mode = 16'h1000;
        tick(1);
        checks++; if (busy !== 8'h40) begin errors++; $display("FAIL to_entry got %h exp 40", busy); end
        tick(1023);
        checks++; if (frozen !== 8'h00 || err !== 8'h00 || busy !== 8'h40) begin errors++; $display("FAIL to_1023 got frozen %h err %h busy %h exp 00 00 40", frozen, err, busy); end
        tick(1);
        checks++; if (frozen !== 8'h40 || err !== 8'h40 || busy !== 8'h00) begin errors++; $display("FAIL to_1024 got frozen %h err %h busy %h exp 40 40 00", frozen, err, busy); end
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        checks++; if (err !== 8'h00) begin errors++; $display("FAIL err_clr got %h exp 00", err); end
        rif.adc_cal_frozen[7] = 1'b1;
        tick(3);
        mode = 16'h5000;
        tick(2);
        checks++; if (frozen[7] !== 1'b1) begin errors++; $display("FAIL ch7_frozen got %b exp 1", frozen[7]); end
        mode = 16'h1000;
        tick(1);
        checks++; if (busy[7] !== 1'b1 || rif.adc_cal_freeze[7] !== 1'b0) begin errors++; $display("FAIL thaw_wait_entry got busy %b freeze %b exp 1 0", busy[7], rif.adc_cal_freeze[7]); end
        tick(1023);
        checks++; if (busy[7] !== 1'b1 || err[7] !== 1'b0) begin errors++; $display("FAIL thaw_to_1023 got busy %b err %b exp 1 0", busy[7], err[7]); end
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        checks++; if (err !== 8'h80 || busy[7] !== 1'b0) begin errors++; $display("FAIL set_wins got err %h busy %b exp 80 0", err, busy[7]); end
        rif.adc_cal_frozen[7] = 1'b0;
        tick(3);
    endtask

    task automatic test_reset_mid();
        mode = 16'h1010;
        tick(1);
        checks++; if (rif.adc_cal_freeze !== 8'h44 || busy[2] !== 1'b1) begin errors++; $display("FAIL mid_pre got freeze %h busy %b exp 44 1", rif.adc_cal_freeze, busy[2]); end
        #2 aresetn = 1'b0;
        #1;
        checks++; if (rif.adc_cal_freeze !== 8'h00) begin errors++; $display("FAIL mid_async got %h exp 00", rif.adc_cal_freeze); end
        checks++; if ({frozen, busy, err} !== 24'h0) begin errors++; $display("FAIL mid_status got %h exp 000000", {frozen, busy, err}); end
        mode = '0;
        tick(2);
        aresetn = 1'b1;
        tick(3);
        checks++; if (rif.adc_cal_freeze !== 8'h00 || busy !== 8'h00 || frozen !== 8'h00) begin errors++; $display("FAIL mid_release got freeze %h busy %h frozen %h exp 00 00 00", rif.adc_cal_freeze, busy, frozen); end
        mode = 16'h0010;
        tick(1);
        checks++; if (rif.adc_cal_freeze !== 8'h04 || busy !== 8'h04) begin errors++; $display("FAIL mid_restart got freeze %h busy %h exp 04 04", rif.adc_cal_freeze, busy); end
        mode = '0;
    endtask

    initial begin
        test_reset();
        test_auto_freeze();
        test_glitch_and_zero_dwell();
        test_force_never();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
